// File: rtl/roclk_feat_loader_if.sv
// Stream bundle for the feature loader: feature beats in, captured prediction out.
interface roclk_feat_loader_if #(
    parameter int unsigned FEAT_BITS = 4,
    parameter int unsigned PRED_BITS = 2
);
    logic                 s_valid;
    logic                 s_ready;
    logic [FEAT_BITS-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [PRED_BITS-1:0] m_pred;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_pred
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_pred
    );
endinterface

// File: rtl/roclk_feat_loader.sv
// Feature loader / inference sequencer: assembles a feature vector, runs the BNN classifier
// out of reset for a fixed window, then captures its prediction into a valid/ready register.
module roclk_feat_loader #(
    parameter int unsigned FEAT_CNT   = 4,
    parameter int unsigned FEAT_BITS  = 4,
    parameter int unsigned HIDDEN_CNT = 4,
    parameter int unsigned CLASS_CNT  = 4,
    parameter int unsigned RUN_CYCLES = 2 * HIDDEN_CNT + 2,
    localparam int unsigned PredBits  = (CLASS_CNT > 2) ? $clog2(CLASS_CNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    roclk_feat_loader_if.slave            bus,
    output logic [FEAT_CNT*FEAT_BITS-1:0] feat_out,
    output logic                          clf_rst,
    input  logic [PredBits-1:0]           clf_pred,
    output logic                          busy
);
    localparam int unsigned IdxW  = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int unsigned CntW  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int unsigned FeatW = FEAT_CNT * FEAT_BITS;

    localparam logic [IdxW-1:0] IdxLast = IdxW'(FEAT_CNT - 1);
    localparam logic [CntW-1:0] RunLast = CntW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {StLoad, StRun, StOut} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FeatW-1:0]    feat_q, feat_d;
    logic                clf_rst_q, clf_rst_d;
    logic                m_valid_q, m_valid_d;
    logic [PredBits-1:0] m_pred_q, m_pred_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        feat_d    = feat_q;
        clf_rst_d = clf_rst_q;
        m_valid_d = m_valid_q;
        m_pred_d  = m_pred_q;
        unique case (state_q)
            StLoad: begin
                if (bus.s_valid) begin
                    for (int unsigned i = 0; i < FEAT_CNT; i++) begin
                        if (idx_q == IdxW'(i)) begin
                            feat_d[i*FEAT_BITS +: FEAT_BITS] = bus.s_data;
                        end
                    end
                    if (idx_q == IdxLast) begin
                        // Release the classifier on the same edge as the final beat.
                        idx_d     = '0;
                        cnt_d     = '0;
                        clf_rst_d = 1'b0;
                        state_d   = StRun;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StRun: begin
                if (cnt_q == RunLast) begin
                    m_pred_d  = clf_pred;
                    m_valid_d = 1'b1;
                    clf_rst_d = 1'b1;
                    state_d   = StOut;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOut: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLoad;
            idx_q     <= '0;
            cnt_q     <= '0;
            feat_q    <= '0;
            clf_rst_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_pred_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            feat_q    <= feat_d;
            clf_rst_q <= clf_rst_d;
            m_valid_q <= m_valid_d;
            m_pred_q  <= m_pred_d;
        end
    end

    assign bus.s_ready = (state_q == StLoad);
    assign bus.m_valid = m_valid_q;
    assign bus.m_pred  = m_pred_q;
    assign busy        = (state_q == StRun) || (state_q == StOut);
    assign feat_out    = feat_q;
    assign clf_rst     = clf_rst_q;
endmodule

// File: tb/tb_roclk_feat_loader.sv
// Directed bench for roclk_feat_loader: vector table plus stall, backpressure,
// back-to-back and mid-operation reset sequences.
module tb_roclk_feat_loader;
    localparam int unsigned Run = 10;  // 2*HIDDEN_CNT+2 with defaults

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] feat_out;
    logic        clf_rst;
    logic [1:0]  clf_pred;
    logic [1:0]  forced_pred;
    logic        use_model;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    roclk_feat_loader_if #(.FEAT_BITS(4), .PRED_BITS(2)) bus ();

    roclk_feat_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .feat_out (feat_out),
        .clf_rst  (clf_rst),
        .clf_pred (clf_pred),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Stand-in classifier: a feature-dependent class while out of reset.
    assign clf_pred = use_model ? (clf_rst ? 2'd0 : (feat_out[1:0] ^ feat_out[5:4])) : forced_pred;

    typedef struct {
        logic [15:0] beats;
        logic [1:0]  pred;
        logic [15:0] exp_feat;
        logic [1:0]  exp_pred;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beats(input logic [15:0] beats, input logic [15:0] exp_feat);
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = beats[i*4 +: 4];
            step();
            if (i < 3) begin
                chk("clf_rst_during_load", 32'(clf_rst), 32'd1);
            end else begin
                chk("clf_rst_after_last_beat", 32'(clf_rst), 32'd0);
                chk("feat_after_load", 32'(feat_out), 32'(exp_feat));
                chk("s_ready_in_run", 32'(bus.s_ready), 32'd0);
                chk("busy_in_run", 32'(busy), 32'd1);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic run_to_out(input logic [1:0] exp_pred, input logic [15:0] exp_feat);
        int k = 0;
        while (!bus.m_valid && k < 4 * Run) begin
            step();
            k++;
        end
        chk("m_valid_latency", 32'(k), 32'(Run));
        chk("m_pred_captured", 32'(bus.m_pred), 32'(exp_pred));
        chk("clf_rst_in_out", 32'(clf_rst), 32'd1);
        chk("s_ready_in_out", 32'(bus.s_ready), 32'd0);
        chk("feat_frozen", 32'(feat_out), 32'(exp_feat));
    endtask

    task automatic handshake();
        bus.m_ready = 1'b1;
        step();
        chk("m_valid_after_hs", 32'(bus.m_valid), 32'd0);
        chk("s_ready_after_hs", 32'(bus.s_ready), 32'd1);
        chk("busy_after_hs", 32'(busy), 32'd0);
        bus.m_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pat;
        logic [3:0] seq [8];
        int         bi;
        int         ptr;
        int         hi_cnt;
        int         t_hi [2];
        logic [1:0] p_hi [2];
        logic       hs;

        vecs[0] = '{16'h4321, 2'd2, 16'h4321, 2'd2};
        vecs[1] = '{16'h5A0F, 2'd1, 16'h5A0F, 2'd1};
        vecs[2] = '{16'h0000, 2'd3, 16'h0000, 2'd3};
        vecs[3] = '{16'hFFFF, 2'd0, 16'hFFFF, 2'd0};

        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        forced_pred = 2'd0;
        use_model   = 1'b0;
        #12;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_clf_rst", 32'(clf_rst), 32'd1);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_pred", 32'(bus.m_pred), 32'd0);
        chk("rst_feat", 32'(feat_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: each sample loaded, run, and drained; a spurious beat is held during RUN.
        for (int v = 0; v < 4; v++) begin
            forced_pred = vecs[v].pred;
            load_beats(vecs[v].beats, vecs[v].exp_feat);
            bus.s_valid = 1'b1;
            bus.s_data  = 4'hE;
            run_to_out(vecs[v].exp_pred, vecs[v].exp_feat);
            bus.s_valid = 1'b0;
            handshake();
        end

        // Stalled input; previous vector is 0xFFFF and is overwritten slot by slot.
        pat = 7'b1011001;
        bi  = 0;
        for (int c = 0; c < 7; c++) begin
            bus.s_valid = pat[c];
            bus.s_data  = 4'(bi + 1);
            step();
            if (pat[c]) bi++;
            if (bi < 4) chk("stall_clf_rst_high", 32'(clf_rst), 32'd1);
            if (c == 0) chk("stall_partial_feat", 32'(feat_out), 32'hFFF1);
        end
        bus.s_valid = 1'b0;
        chk("stall_clf_rst_low", 32'(clf_rst), 32'd0);
        chk("stall_feat", 32'(feat_out), 32'h4321);
        forced_pred = 2'd2;
        run_to_out(2'd2, 16'h4321);

        // Output backpressure while the classifier output moves.
        forced_pred = 2'd3;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_m_pred", 32'(bus.m_pred), 32'd2);
            chk("bp_m_valid", 32'(bus.m_valid), 32'd1);
            chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
        end
        handshake();

        // Back-to-back samples with m_ready tied high.
        use_model   = 1'b1;
        bus.m_ready = 1'b1;
        seq    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'h7, 4'h0, 4'h0};
        ptr    = 0;
        hi_cnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.s_valid = (ptr < 8);
            bus.s_data  = (ptr < 8) ? seq[ptr] : 4'h0;
            hs          = bus.s_valid && bus.s_ready;
            step();
            if (hs) ptr++;
            if (bus.m_valid) begin
                if (hi_cnt < 2) begin
                    t_hi[hi_cnt] = cyc;
                    p_hi[hi_cnt] = bus.m_pred;
                end
                hi_cnt++;
            end
        end
        bus.s_valid = 1'b0;
        chk("b2b_pulse_cycles", 32'(hi_cnt), 32'd2);
        chk("b2b_first_rise", 32'(t_hi[0]), 32'd14);
        chk("b2b_interval", 32'(t_hi[1] - t_hi[0]), 32'd15);
        chk("b2b_pred0", 32'(p_hi[0]), 32'd3);
        chk("b2b_pred1", 32'(p_hi[1]), 32'd2);
        use_model   = 1'b0;
        bus.m_ready = 1'b0;

        // Reset 5 cycles into RUN.
        forced_pred = 2'd2;
        load_beats(16'h4321, 16'h4321);
        for (int c = 0; c < 5; c++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_clf_rst", 32'(clf_rst), 32'd1);
        chk("rst_run_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_run_feat", 32'(feat_out), 32'd0);
        chk("rst_run_s_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        load_beats(16'h4321, 16'h4321);
        run_to_out(2'd2, 16'h4321);

        // Reset while a prediction is pending drops m_valid at once.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_out_m_pred", 32'(bus.m_pred), 32'd0);
        chk("rst_out_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
